// File: rtl/div_sched.sv
// rtl/div_sched.sv - round-robin scheduler sharing one pipelined signed divider among N requesters
// Optional feature macro: DIV_SCHED_DZ_EN (zero-divisor saturation of the returned quotient).
module div_sched #(
  parameter int WIDTH   = 48,
  parameter int N       = 4,
  parameter int DIV_LAT = WIDTH + 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req_valid,
  input  logic [N*WIDTH-1:0]   i_req_x,
  input  logic [N*WIDTH-1:0]   i_req_y,
  output logic [N-1:0]         o_req_ready,
  output logic                 o_div_en,
  output logic [WIDTH-1:0]     o_div_x,
  output logic [WIDTH-1:0]     o_div_y,
  input  logic [WIDTH-1:0]     i_div_z,
  output logic [N-1:0]         o_res_valid,
  output logic [WIDTH-1:0]     o_res_z,
  output logic                 o_res_dz
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0]   rr_q, rr_d;
  logic [DIV_LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]   tag_id_q [DIV_LAT];
  logic [IDW-1:0]   tag_id_d [DIV_LAT];
  logic [N-1:0]     res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;

  logic             blocked;
  logic             grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;

`ifdef DIV_SCHED_DZ_EN
  logic [DIV_LAT-1:0] tag_dz_q, tag_dz_d;
  logic [DIV_LAT-1:0] tag_sx_q, tag_sx_d;
  logic               res_dz_q, res_dz_d;
`endif

  // Round-robin pick: first valid requester at or after rr, suppressed in the blackout cycle and in reset.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // An issue DIV_LAT-1 cycles ago sits in entry DIV_LAT-2 now; this cycle is its output-capture slot.
    blocked   = tag_v_q[DIV_LAT-2];
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!grant && !blocked && !i_rst && i_req_valid[cand[IDW-1:0]]) begin
        grant     = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Grant fan-out to the requester handshake and the divider operands; rr advances past the winner.
  always_comb begin
    o_req_ready = '0;
    o_div_en    = grant;
    o_div_x     = '0;
    o_div_y     = '0;
    rr_d        = rr_q;
    if (grant) begin
      o_req_ready[grant_idx] = 1'b1;
      o_div_x = i_req_x[int'(grant_idx)*WIDTH +: WIDTH];
      o_div_y = i_req_y[int'(grant_idx)*WIDTH +: WIDTH];
      rr_d    = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Tag delay line: entry 0 takes the new issue, everything else shifts by one each cycle.
  always_comb begin
    tag_v_d     = {tag_v_q[DIV_LAT-2:0], grant};
    tag_id_d[0] = grant_idx;
    for (int i = 1; i < DIV_LAT; i++) begin
      tag_id_d[i] = tag_id_q[i-1];
    end
`ifdef DIV_SCHED_DZ_EN
    tag_dz_d = {tag_dz_q[DIV_LAT-2:0], grant && (o_div_y == '0)};
    tag_sx_d = {tag_sx_q[DIV_LAT-2:0], grant && o_div_x[WIDTH-1]};
`endif
  end

  // Retire: when the last tag entry is valid the divider output holds its quotient; capture and pulse the owner.
  always_comb begin
    res_valid_d = '0;
    res_z_d     = res_z_q;
`ifdef DIV_SCHED_DZ_EN
    res_dz_d    = res_dz_q;
`endif
    if (tag_v_q[DIV_LAT-1]) begin
      res_valid_d[tag_id_q[DIV_LAT-1]] = 1'b1;
      res_z_d = i_div_z;
`ifdef DIV_SCHED_DZ_EN
      res_dz_d = tag_dz_q[DIV_LAT-1];
      if (tag_dz_q[DIV_LAT-1]) begin
        // Saturate toward the sign of the dividend instead of trusting the divider's zero-divisor output.
        res_z_d = tag_sx_q[DIV_LAT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  // State registers; reset drops every in-flight tag so no stale result pulses can follow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q        <= '0;
      tag_v_q     <= '0;
      res_valid_q <= '0;
      res_z_q     <= '0;
      for (int i = 0; i < DIV_LAT; i++) begin
        tag_id_q[i] <= '0;
      end
`ifdef DIV_SCHED_DZ_EN
      tag_dz_q <= '0;
      tag_sx_q <= '0;
      res_dz_q <= 1'b0;
`endif
    end else begin
      rr_q        <= rr_d;
      tag_v_q     <= tag_v_d;
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
      for (int i = 0; i < DIV_LAT; i++) begin
        tag_id_q[i] <= tag_id_d[i];
      end
`ifdef DIV_SCHED_DZ_EN
      tag_dz_q <= tag_dz_d;
      tag_sx_q <= tag_sx_d;
      res_dz_q <= res_dz_d;
`endif
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_res_z     = res_z_q;
`ifdef DIV_SCHED_DZ_EN
  assign o_res_dz    = res_dz_q;
`else
  assign o_res_dz    = 1'b0;
`endif

endmodule
